// File: rtl/frame_shift_engine.sv
// Serial frame engine: shifts one W-bit config word out on sdi per latch frame and
// captures W returned sdo bits. Optional LOOPBACK_CHECK_EN adds lb_mismatch.
module frame_shift_engine #(
   parameter int BIT_CHIP = 6,
   parameter int NODE     = 16,
   parameter int W        = BIT_CHIP * NODE,
   parameter int CW       = $clog2(W + 1)
) (
   input  logic          clk_main,
   input  logic          clr,
   input  logic          clk_data_de2,
   input  logic          latch,
   input  logic          load_valid,
   input  logic [W-1:0]  load_data,
   output logic          load_ready,
   output logic          sdi,
   input  logic          sdo,
   output logic [W-1:0]  cap_data,
   output logic          cap_valid,
   output logic          frame_err,
   output logic [CW-1:0] bit_cnt
`ifdef LOOPBACK_CHECK_EN
   ,
   output logic          lb_mismatch
`endif
);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   localparam logic [CW-1:0] W_CNT = CW'(W);

   state_t         state, state_nxt;
   logic           clk_prev, latch_prev;
   logic           stg_full, stg_full_nxt;
   logic [W-1:0]   stg_data, stg_data_nxt;
   logic [W-1:0]   tx, tx_nxt;
   logic [W-1:0]   tx_word, tx_word_nxt;
   logic [W-1:0]   rx, rx_nxt;
   logic [CW-1:0]  cnt_nxt;
   logic           ovf, ovf_nxt;
   logic [W-1:0]   cap_nxt;
   logic           cv_nxt, fe_nxt;
   logic           d_rise, d_fall, l_rise, l_fall;
   logic           accept, xfer, capture;

   assign d_rise     = clk_data_de2 & ~clk_prev;
   assign d_fall     = ~clk_data_de2 & clk_prev;
   assign l_rise     = latch & ~latch_prev;
   assign l_fall     = ~latch & latch_prev;
   assign load_ready = ~stg_full;
   assign accept     = load_valid & ~stg_full;

   always_comb begin
      state_nxt   = state;
      tx_nxt      = tx;
      tx_word_nxt = tx_word;
      rx_nxt      = rx;
      cnt_nxt     = bit_cnt;
      ovf_nxt     = ovf;
      cap_nxt     = cap_data;
      cv_nxt      = 1'b0;
      fe_nxt      = 1'b0;
      xfer        = 1'b0;
      capture     = 1'b0;
      case (state)
         IDLE: begin
            if (l_fall) begin
               // tx_word keeps the whole frame word so an empty stage repeats it
               xfer        = 1'b1;
               tx_nxt      = stg_full ? stg_data : tx_word;
               tx_word_nxt = tx_nxt;
               cnt_nxt     = '0;
               ovf_nxt     = 1'b0;
               state_nxt   = SHIFT;
            end
         end
         SHIFT: begin
            if (d_rise) begin
               rx_nxt  = {rx[W-2:0], sdo};
               cnt_nxt = bit_cnt + CW'(1);
            end else if (d_fall && bit_cnt != '0) begin
               tx_nxt = {tx[W-2:0], 1'b0};
            end
            // data edge already folded into cnt_nxt/rx_nxt before the latch decision
            if (l_rise) begin
               state_nxt = IDLE;
               if (cnt_nxt == W_CNT) capture = 1'b1;
               else                  fe_nxt  = 1'b1;
            end else if (cnt_nxt == W_CNT) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            ovf_nxt = ovf | d_rise;
            if (l_rise) begin
               state_nxt = IDLE;
               if (ovf_nxt) fe_nxt  = 1'b1;
               else         capture = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (capture) begin
         cap_nxt = rx_nxt;
         cv_nxt  = 1'b1;
      end
      // a same-cycle accept wins: the transfer above already used the old content
      stg_full_nxt = accept ? 1'b1 : (xfer ? 1'b0 : stg_full);
      stg_data_nxt = accept ? load_data : stg_data;
   end

   always_ff @(posedge clk_main or posedge clr) begin
      if (clr) begin
         state      <= IDLE;
         clk_prev   <= 1'b1;
         latch_prev <= 1'b0;
         stg_full   <= 1'b0;
         stg_data   <= '0;
         tx         <= '0;
         tx_word    <= '0;
         rx         <= '0;
         bit_cnt    <= '0;
         ovf        <= 1'b0;
         cap_data   <= '0;
         cap_valid  <= 1'b0;
         frame_err  <= 1'b0;
         sdi        <= 1'b0;
      end else begin
         state      <= state_nxt;
         clk_prev   <= clk_data_de2;
         latch_prev <= latch;
         stg_full   <= stg_full_nxt;
         stg_data   <= stg_data_nxt;
         tx         <= tx_nxt;
         tx_word    <= tx_word_nxt;
         rx         <= rx_nxt;
         bit_cnt    <= cnt_nxt;
         ovf        <= ovf_nxt;
         cap_data   <= cap_nxt;
         cap_valid  <= cv_nxt;
         frame_err  <= fe_nxt;
         sdi        <= tx_nxt[W-1];
      end
   end

`ifdef LOOPBACK_CHECK_EN
   logic lb_q;

   always_ff @(posedge clk_main or posedge clr) begin
      if (clr) lb_q <= 1'b0;
      else     lb_q <= capture && (rx_nxt != tx_word);
   end

   assign lb_mismatch = lb_q;
`endif

endmodule

// File: tb/tb_frame_shift_engine.sv
// Directed table-driven bench for frame_shift_engine; sdo loops back to sdi unless
// a vector forces it low. Build with LOOPBACK_CHECK_EN to also check lb_mismatch.
module tb_frame_shift_engine;

   localparam int W  = 96;
   localparam int CW = 7;

   logic          clk_main = 1'b0;
   logic          clr, clk_data_de2, latch, load_valid, loop;
   logic [W-1:0]  load_data, cap_data;
   logic          load_ready, sdi, sdo, cap_valid, frame_err;
   logic [CW-1:0] bit_cnt;
   logic          lb_mismatch;

   frame_shift_engine #(.BIT_CHIP(6), .NODE(16)) dut (
      .clk_main(clk_main), .clr(clr), .clk_data_de2(clk_data_de2), .latch(latch),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .sdi(sdi), .sdo(sdo), .cap_data(cap_data), .cap_valid(cap_valid),
      .frame_err(frame_err), .bit_cnt(bit_cnt)
`ifdef LOOPBACK_CHECK_EN
      , .lb_mismatch(lb_mismatch)
`endif
   );

`ifndef LOOPBACK_CHECK_EN
   assign lb_mismatch = 1'b0;
`endif

   always #5 clk_main = ~clk_main;
   assign sdo = loop ? sdi : 1'b0;

   int n_run = 0, n_fail = 0;
   int cv_tot = 0, fe_tot = 0, lb_tot = 0;

   always @(negedge clk_main) begin
      if (cap_valid)   cv_tot++;
      if (frame_err)   fe_tot++;
      if (lb_mismatch) lb_tot++;
   end

   typedef struct {
      int           nrise;
      logic         pre_ld;
      logic         fall_ld;
      logic [W-1:0] word;
      logic         sim;
      logic         lp;
      int           exp_cv;
      int           exp_fe;
      logic [W-1:0] exp_cap;
      int           exp_cnt;
      logic         chk_sdi;
      logic [W-1:0] exp_sdi;
      logic         exp_rdy;
      int           exp_lb;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(int n, logic pre, logic fl, logic [W-1:0] wd, logic sm,
                               logic lp, int cv, int fe, logic [W-1:0] cap, int cnt,
                               logic cs, logic [W-1:0] sb, logic rdy, int lb);
      vec_t v;
      v.nrise = n; v.pre_ld = pre; v.fall_ld = fl; v.word = wd; v.sim = sm; v.lp = lp;
      v.exp_cv = cv; v.exp_fe = fe; v.exp_cap = cap; v.exp_cnt = cnt;
      v.chk_sdi = cs; v.exp_sdi = sb; v.exp_rdy = rdy; v.exp_lb = lb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // one data-clock period: 2 cycles high, 2 low; sdi recorded just before the rise
   task automatic d_pulse(input logic with_latch, inout logic [W-1:0] bits);
      @(negedge clk_main);
      bits = {bits[W-2:0], sdi};
      clk_data_de2 = 1'b1;
      if (with_latch) latch = 1'b1;
      @(negedge clk_main);
      @(negedge clk_main);
      clk_data_de2 = 1'b0;
      @(negedge clk_main);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [W-1:0] bits = '0;
      int cv0, fe0, lb0;
      loop = v.lp;
      if (v.pre_ld) begin
         @(negedge clk_main);
         load_valid = 1'b1; load_data = v.word;
         @(negedge clk_main);
         load_valid = 1'b0;
      end
      @(negedge clk_main);
      cv0 = cv_tot; fe0 = fe_tot; lb0 = lb_tot;
      latch = 1'b0;
      if (v.fall_ld) begin
         load_valid = 1'b1; load_data = v.word;
      end
      @(negedge clk_main);
      load_valid = 1'b0;
      for (int i = 0; i < v.nrise; i++) d_pulse(v.sim && (i == v.nrise - 1), bits);
      if (!v.sim) begin
         @(negedge clk_main);
         latch = 1'b1;
      end
      repeat (4) @(negedge clk_main);
      chk($sformatf("v%0d cap_valid pulses", idx), W'(cv_tot - cv0), W'(v.exp_cv));
      chk($sformatf("v%0d frame_err pulses", idx), W'(fe_tot - fe0), W'(v.exp_fe));
      chk($sformatf("v%0d cap_data", idx), cap_data, v.exp_cap);
      chk($sformatf("v%0d bit_cnt", idx), W'(bit_cnt), W'(v.exp_cnt));
      chk($sformatf("v%0d load_ready", idx), W'(load_ready), W'(v.exp_rdy));
      if (v.chk_sdi) chk($sformatf("v%0d sdi bits", idx), bits, v.exp_sdi);
`ifdef LOOPBACK_CHECK_EN
      chk($sformatf("v%0d lb_mismatch pulses", idx), W'(lb_tot - lb0), W'(v.exp_lb));
`endif
   endtask

   initial begin
      logic [W-1:0] wa5, w2, w3, w1, bits;
      int cv0, fe0;
      wa5 = {12{8'hA5}};
      w2  = 96'h0123_4567_89AB_CDEF_F0E1_D2C3;
      w3  = 96'hDEAD_BEEF_0F0F_3C3C_8001_7FFE;
      w1  = 96'h1;
      //            n  pre fl word sim lp cv fe cap  cnt sdi? sdi  rdy lb
      vecs[0]  = mk(96, 1, 0, wa5, 0, 1, 1, 0, wa5, 96, 1, wa5, 1, 0);
      vecs[1]  = mk(96, 0, 0, '0,  0, 1, 1, 0, wa5, 96, 1, wa5, 1, 0);
      vecs[2]  = mk(50, 1, 0, w2,  0, 1, 0, 1, wa5, 50, 0, '0,  1, 0);
      vecs[3]  = mk(96, 0, 0, '0,  0, 1, 1, 0, w2,  96, 1, w2,  1, 0);
      vecs[4]  = mk(97, 0, 0, '0,  0, 1, 0, 1, w2,  96, 0, '0,  1, 0);
      vecs[5]  = mk(96, 0, 0, '0,  0, 1, 1, 0, w2,  96, 1, w2,  1, 0);
      vecs[6]  = mk(96, 0, 1, w3,  0, 1, 1, 0, w2,  96, 1, w2,  0, 0);
      vecs[7]  = mk(96, 0, 0, '0,  0, 1, 1, 0, w3,  96, 1, w3,  1, 0);
      vecs[8]  = mk(96, 0, 0, '0,  1, 1, 1, 0, w3,  96, 1, w3,  1, 0);
      vecs[9]  = mk(96, 1, 0, w1,  0, 0, 1, 0, '0,  96, 1, w1,  1, 1);
      vecs[10] = mk(96, 0, 0, '0,  0, 1, 1, 0, w1,  96, 1, w1,  1, 0);
      vecs[11] = mk(95, 0, 0, '0,  1, 1, 0, 1, w1,  95, 0, '0,  1, 0);

      clr = 1'b1; clk_data_de2 = 1'b0; latch = 1'b0; load_valid = 1'b0;
      load_data = '0; loop = 1'b1;
      repeat (3) @(negedge clk_main);
      clr = 1'b0;
      @(negedge clk_main);
      chk("reset load_ready", W'(load_ready), W'(1));
      chk("reset cap_valid", W'(cap_valid), W'(0));
      chk("reset frame_err", W'(frame_err), W'(0));
      chk("reset sdi", W'(sdi), W'(0));
      chk("reset bit_cnt", W'(bit_cnt), W'(0));
      chk("reset cap_data", cap_data, '0);
      latch = 1'b1;
      @(negedge clk_main);

      for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

      // reset in the middle of a frame: frame abandoned, nothing published
      loop = 1'b1;
      bits = '0;
      @(negedge clk_main);
      cv0 = cv_tot; fe0 = fe_tot;
      latch = 1'b0;
      for (int i = 0; i < 10; i++) d_pulse(1'b0, bits);
      chk("midreset pre bit_cnt", W'(bit_cnt), W'(10));
      @(negedge clk_main);
      clr = 1'b1;
      #1;
      chk("midreset bit_cnt", W'(bit_cnt), W'(0));
      chk("midreset cap_data", cap_data, '0);
      chk("midreset sdi", W'(sdi), W'(0));
      @(negedge clk_main);
      clr = 1'b0;
      latch = 1'b1;
      repeat (4) @(negedge clk_main);
      chk("midreset cap_valid pulses", W'(cv_tot - cv0), W'(0));
      chk("midreset frame_err pulses", W'(fe_tot - fe0), W'(0));
      chk("midreset load_ready", W'(load_ready), W'(1));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/frame_shift_engine.md
Name: frame_shift_engine

Overview:
Serial frame engine directly downstream of the landscape-sampling clock generator. It consumes the gated clk_data_de2 burst and the latch pulse and, per clk_low frame, shifts one BIT_CHIP*NODE-bit configuration word out to the chip (sdi). It captures the same number of returned bits (sdo) and publishes them as a parallel word at latch. Fully synchronous to clk_main; clk_data_de2 and latch are treated as data and edge-detected.

Parameters:
BIT_CHIP, 6, bits per node
NODE, 16, nodes per chip
W, BIT_CHIP*NODE, frame length in bits (derived; must be >=2)
CW, $clog2(W+1), bit-counter width

Ports:
clk_main  in  1  system clock
clr  in  1  reset
clk_data_de2  in  1  gated data clock from the clock generator (clk_main domain)
latch  in  1  frame-end latch pulse from the clock generator
load_valid  in  1  staged config word offered
load_data  in  W  config word; MSB is shifted first
load_ready  out  1  staging buffer empty
sdi  out  1  serial data to chip
sdo  in  1  serial data from chip
cap_data  out  W  last captured word; first received bit lands in MSB
cap_valid  out  1  one-cycle pulse when cap_data updates
frame_err  out  1  one-cycle pulse on a bad frame
bit_cnt  out  CW  rising edges counted in the current frame

Behaviour:
- Reset: clr is asynchronous and active-high; the clock is clk_main.
  - Reset values: sdi=0, cap_data=0, cap_valid=0, frame_err=0, bit_cnt=0, load_ready=1.
  - Internal state: staging empty, tx shift reg=0, rx shift reg=0, clk_prev=1, latch_prev=0, state=IDLE.
  - Reset mid-frame abandons the frame; no cap_valid is produced for it.
- Edge detect:
  - d_rise = clk_data_de2 & ~clk_prev; d_fall = ~clk_data_de2 & clk_prev.
  - l_rise = latch & ~latch_prev; l_fall = ~latch & latch_prev.
- Staging handshake:
  - A word is accepted when load_valid & load_ready; the staging buffer becomes full and load_ready drops the next cycle.
  - The staging buffer empties on the transfer described at l_fall.
  - If accept and transfer fall in the same cycle, the transfer takes the old content and the new word stays staged (load_ready stays 0).
- States:
  - IDLE: sdi=tx[W-1]; data edges are ignored. l_fall -> SHIFT.
  - SHIFT:
    - d_rise: rx <= {rx[W-2:0], sdo}; bit_cnt++. When bit_cnt reaches W -> HOLD.
    - d_fall with 0<bit_cnt<W: tx <= {tx[W-2:0], 1'b0}.
    - l_rise -> IDLE with frame_err pulse (short frame).
  - HOLD:
    - Further d_rise: sets a sticky overflow flag; rx and bit_cnt are unchanged.
    - l_rise: if no overflow, cap_data <= rx and cap_valid=1; if overflow, frame_err=1 and cap_data holds. Then -> IDLE.
- At every l_fall (entering SHIFT):
  - tx <= staging when full, else tx <= last transmitted word (repeat).
  - bit_cnt <= 0 and overflow flag cleared.
- Output timing:
  - sdi = tx[W-1], registered; it changes the cycle after d_fall.
  - cap_valid and frame_err are asserted the cycle after the l_rise sample and last exactly one cycle.
- Simultaneous events:
  - d_rise and l_rise in the same cycle: the data edge is processed first, then the latch decision.
  - d_rise and d_fall cannot coincide.
- Widths: bit_cnt saturates at W and never wraps.

Optional Feature:
LOOPBACK_CHECK_EN:
- Defined: adds output port lb_mismatch (1 bit). At each cap_valid, lb_mismatch pulses for that same cycle if the captured word differs from the word transmitted in that frame. Supports chip daisy-chain/loopback self-test.
- Undefined: no port and no comparison logic.

Test Plan:
- Reset: hold clr 3 cycles, release -> load_ready=1, cap_valid=0, sdi=0, bit_cnt=0.
- Normal frame, sdo looped to sdi:
  - Stimulus: load 96'hA5...A5 (W=96), drive the clock generator (r_data_to_low=100).
  - Required: sdi shows 1,0,1,0,0,1,0,1... from the first SHIFT cycle; cap_valid pulses once after latch rise; cap_data=96'hA5...A5; bit_cnt=96.
- Short frame: latch rise after 50 d_rise -> frame_err=1 for one cycle, cap_valid=0, cap_data unchanged.
- Overflow: 97 d_rise before latch -> frame_err pulse, cap_data unchanged; the next normal frame captures correctly.
- Staging and repeat:
  - No load before the second frame -> the previous word is re-sent.
  - Load asserted in the same cycle as l_fall -> the old word is sent, the new word is sent the following frame, and load_ready stays 0 until that frame's l_fall.
- Loopback check (LOOPBACK_CHECK_EN): sdo forced to 0 with tx=96'h1 -> lb_mismatch=1 coincident with cap_valid; sdo looped -> lb_mismatch=0.
